wb_writer: RTL and testbench
============================

// Module: wb_writer
// PURPOSE
//  Writeback-stage writer for the 8x8 register file. Merges two result sources: the single-cycle
//  ALU result (never stalls) and the load unit result (valid/ready, buffered). Drives the register
//  file write port (RegWrite / write_reg_num / write_data). Keeps a per-register pending scoreboard
//  for the hazard unit in the decode stage.
// PARAMETERS
//  DATA_W    8  result / register data width
//  ADDR_W    3  register index width (2**ADDR_W registers)
//  LQ_DEPTH  2  load queue entries; power of 2, >= 2
// PORTS
//  clk            in   1         rising-edge clock
//  rst            in   1         synchronous, active-high reset
//  alu_valid      in   1         ALU result present this cycle
//  alu_rd         in   ADDR_W    ALU destination register
//  alu_data       in   DATA_W    ALU result
//  ld_valid       in   1         load result offered
//  ld_ready       out  1         load queue can accept (= !full); combinational from state
//  ld_rd          in   ADDR_W    load destination register
//  ld_data        in   DATA_W    load data
//  issue_valid    in   1         decode issues instruction that writes issue_rd
//  issue_rd       in   ADDR_W    destination of the issuing instruction
//  pending        out  2**ADDR_W bit r = write to register r outstanding
//  RegWrite       out  1         register file write enable (registered)
//  write_reg_num  out  ADDR_W    register file write index (registered)
//  write_data     out  DATA_W    register file write data (registered)
//  lq_count       out  ADDR_W+1  current load queue occupancy
// BEHAVIOUR
//  - Reset: RegWrite=0, write_reg_num=0, write_data=0, pending=0, queue emptied, lq_count=0.
//    A reset mid-operation discards all queued loads and clears all pending bits.
//  - Load accept: ld_valid && ld_ready at an edge pushes {ld_rd, ld_data} at the tail.
//  - Per-cycle source select (one write per cycle):
//      1) alu_valid          -> ALU wins; the queue holds.
//      2) else queue nonempty -> pop the head.
//      3) else no write: RegWrite=0 next cycle.
//  - Selected result is registered onto the write port: RegWrite=1 for exactly one cycle.
//    ALU latency is 1 cycle (alu_valid at edge N gives RegWrite high after edge N).
//    Load latency with an empty queue and no ALU traffic is 2 cycles (enqueue, then pop).
//  - Register 0 is hardwired: a selected result with rd==0 is consumed (popped or dropped)
//    but RegWrite stays 0. rd==0 never sets a pending bit.
//  - Queue is circular, with head/tail pointers wrapping modulo LQ_DEPTH.
//    full  = (count==LQ_DEPTH); empty = (count==0).
//    Pop and push in the same cycle: count unchanged, FIFO order kept.
//    When full, ld_ready=0 even if a pop occurs that cycle.
//  - Scoreboard: issue_valid sets pending[issue_rd]. A write-port commit
//    (selection registering RegWrite=1) clears pending[rd] at the same edge.
//    Same register set and cleared in the same cycle: set wins.
//  - Back-to-back writes to the same rd commit in selection order; the last one wins
//    in the register file.
//  - ALU starvation of loads is permitted; ld_ready=0 is the only backpressure.
// CONFIGURATION
//  WB_LOAD_BYPASS_EN defined: if queue empty && !alu_valid && ld_valid, the load goes
//    straight to the write port without enqueue. Load latency becomes 1 cycle, and
//    lq_count stays 0 for that load.
//  Not defined: every load passes through the queue (min latency 2). No other
//    behaviour differs.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs 0; ld_ready=1, lq_count=0, pending=8'h00.
//  2. alu_valid, rd=3, data=8'h5A, for 1 cycle -> next cycle RegWrite=1, write_reg_num=3,
//     write_data=8'h5A; then RegWrite=0.
//  3. alu_valid held 4 cycles (rd 1..4) while loads rd=5 (8'h11), rd=6 (8'h22), rd=7 (8'h33)
//     are offered -> first two accepted, then ld_ready=0 with lq_count=2; ALU writes 1..4
//     appear first, then 5/8'h11, 6/8'h22, then 7/8'h33 after it is accepted.
//  4. issue_valid rd=2 -> pending=8'h04. ALU rd=2 commits while issue_valid rd=2 again
//     the same cycle -> pending stays 8'h04. Next ALU rd=2 commit -> pending=8'h00.
//  5. Load rd=0 data=8'hFF -> queue pops, RegWrite never asserts, pending[0] stays 0.
//  6. Queue holds 2 entries, rst=1 for 1 cycle -> lq_count=0, pending=0, no further writes.
//     Bypass build: a single load on an idle pipe gives RegWrite 1 cycle after acceptance.

Source files
------------

// File: rtl/wb_writer.sv
// ---------------------------------------------------------------------------
// wb_writer
//   Writeback-stage writer for the register file. Merges the single-cycle ALU
//   result (never stalls) with load results that arrive over a valid/ready
//   handshake and are buffered in a small circular load queue. Exactly one
//   result per cycle is registered onto the register-file write port. A
//   per-register pending scoreboard is kept for the decode hazard unit.
//
//   Optional feature macro: WB_LOAD_BYPASS_EN
//     When defined, a load offered while the queue is empty and no ALU result
//     is present goes straight to the write port (1-cycle load latency) and is
//     never enqueued.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data   ALU result (highest priority)
//   ld_valid/ld_ready/ld_rd/ld_data  load result handshake
//   issue_valid/issue_rd     decode issue, sets pending[issue_rd]
//   pending                  bit r = write to register r outstanding
//   RegWrite/write_reg_num/write_data  registered register-file write port
//   lq_count                 current load queue occupancy
// ---------------------------------------------------------------------------
module wb_writer #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int LQ_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [ADDR_W-1:0]      ld_rd,
    input  logic [DATA_W-1:0]      ld_data,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_rd,
    output logic [(1<<ADDR_W)-1:0] pending,
    output logic                   RegWrite,
    output logic [ADDR_W-1:0]      write_reg_num,
    output logic [DATA_W-1:0]      write_data,
    output logic [ADDR_W:0]        lq_count
);

    localparam int              PTR_W   = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int              NREG    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LQ_FULL = (ADDR_W+1)'(LQ_DEPTH);

    logic [ADDR_W-1:0] lq_rd   [LQ_DEPTH];
    logic [DATA_W-1:0] lq_data [LQ_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [ADDR_W:0]   count;

    logic              lq_empty;
    logic              lq_full;
    logic              push;
    logic              pop;
    logic              bypass;

    logic              sel_vld_p0;
    logic [ADDR_W-1:0] sel_rd_p0;
    logic [DATA_W-1:0] sel_data_p0;
    logic              commit_p0;
    logic [NREG-1:0]   pending_nxt;

    assign lq_empty = (count == '0);
    assign lq_full  = (count == LQ_FULL);
    assign ld_ready = !lq_full;    // a same-cycle pop does not open a slot
    assign lq_count = count;

    // The queue only drains when the ALU leaves the port free.
    assign pop = !alu_valid && !lq_empty;

`ifdef WB_LOAD_BYPASS_EN
    assign bypass = lq_empty && !alu_valid && ld_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = ld_valid && ld_ready && !bypass;

    // ---- stage p0: source select (ALU > queue head > bypassed load) ----
    always_comb begin
        sel_vld_p0  = 1'b0;
        sel_rd_p0   = '0;
        sel_data_p0 = '0;
        if (alu_valid) begin
            sel_vld_p0  = 1'b1;
            sel_rd_p0   = alu_rd;
            sel_data_p0 = alu_data;
        end else if (pop) begin
            sel_vld_p0  = 1'b1;
            sel_rd_p0   = lq_rd[head];
            sel_data_p0 = lq_data[head];
        end else if (bypass) begin
            sel_vld_p0  = 1'b1;
            sel_rd_p0   = ld_rd;
            sel_data_p0 = ld_data;
        end
    end

    // Register 0 is hardwired: the result is consumed but never written.
    assign commit_p0 = sel_vld_p0 && (sel_rd_p0 != '0);

    // Clear on commit first, then set on issue so a same-register set wins.
    always_comb begin
        pending_nxt = pending;
        if (commit_p0)
            pending_nxt[sel_rd_p0] = 1'b0;
        if (issue_valid && (issue_rd != '0))
            pending_nxt[issue_rd] = 1'b1;
    end

    // Queue control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage carries data only and is qualified by count.
    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd[tail]   <= ld_rd;
            lq_data[tail] <= ld_data;
        end
    end

    // ---- stage p1: registered write port and scoreboard ----
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite      <= 1'b0;
            write_reg_num <= '0;
            write_data    <= '0;
            pending       <= '0;
        end else begin
            RegWrite <= commit_p0;
            if (commit_p0) begin
                write_reg_num <= sel_rd_p0;
                write_data    <= sel_data_p0;
            end
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_wb_writer.sv
// ---------------------------------------------------------------------------
// tb_wb_writer
//   Directed self-checking bench for wb_writer. Inputs change 1 ns after each
//   rising edge; outputs are sampled at the same point, so they reflect the
//   edge just taken.
// ---------------------------------------------------------------------------
module tb_wb_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_valid;
    logic [2:0] alu_rd;
    logic [7:0] alu_data;
    logic       ld_valid;
    logic       ld_ready;
    logic [2:0] ld_rd;
    logic [7:0] ld_data;
    logic       issue_valid;
    logic [2:0] issue_rd;
    logic [7:0] pending;
    logic       RegWrite;
    logic [2:0] write_reg_num;
    logic [7:0] write_data;
    logic [3:0] lq_count;

    int checks = 0;
    int errors = 0;

    wb_writer #(.DATA_W(8), .ADDR_W(3), .LQ_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .pending       (pending),
        .RegWrite      (RegWrite),
        .write_reg_num (write_reg_num),
        .write_data    (write_data),
        .lq_count      (lq_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write-port expectation helper: RegWrite, and index/data when writing.
    task automatic check_wr(input string tag, input logic we, input logic [2:0] rd,
                            input logic [7:0] d);
        check_eq({tag, ".RegWrite"}, 16'(RegWrite), 16'(we));
        if (we) begin
            check_eq({tag, ".reg"},  16'(write_reg_num), 16'(rd));
            check_eq({tag, ".data"}, 16'(write_data),    16'(d));
        end
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        issue_valid = 1'b0; issue_rd = '0;

        // 1. reset
        tick(); tick();
        check_eq("rst.RegWrite", 16'(RegWrite), 16'h0);
        check_eq("rst.reg",      16'(write_reg_num), 16'h0);
        check_eq("rst.data",     16'(write_data), 16'h0);
        check_eq("rst.pending",  16'(pending), 16'h00);
        check_eq("rst.ld_ready", 16'(ld_ready), 16'h1);
        check_eq("rst.lq_count", 16'(lq_count), 16'h0);
        rst = 1'b0;

        // 2. single ALU write
        alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 8'h5A;
        tick();
        check_wr("alu1", 1'b1, 3'd3, 8'h5A);
        alu_valid = 1'b0;
        tick();
        check_wr("alu1.idle", 1'b0, 3'd0, 8'h00);

        // 3. ALU held 4 cycles while three loads are offered
        alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 8'hA1;
        ld_valid = 1'b1; ld_rd = 3'd5; ld_data = 8'h11;
        tick();
        check_wr("t3.e1", 1'b1, 3'd1, 8'hA1);
        check_eq("t3.e1.count", 16'(lq_count), 16'd1);
        check_eq("t3.e1.ready", 16'(ld_ready), 16'd1);
        alu_rd = 3'd2; alu_data = 8'hA2; ld_rd = 3'd6; ld_data = 8'h22;
        tick();
        check_wr("t3.e2", 1'b1, 3'd2, 8'hA2);
        check_eq("t3.e2.count", 16'(lq_count), 16'd2);
        check_eq("t3.e2.ready", 16'(ld_ready), 16'd0);
        alu_rd = 3'd3; alu_data = 8'hA3; ld_rd = 3'd7; ld_data = 8'h33;
        tick();
        check_wr("t3.e3", 1'b1, 3'd3, 8'hA3);
        check_eq("t3.e3.count", 16'(lq_count), 16'd2);
        alu_rd = 3'd4; alu_data = 8'hA4;
        tick();
        check_wr("t3.e4", 1'b1, 3'd4, 8'hA4);
        check_eq("t3.e4.count", 16'(lq_count), 16'd2);
        check_eq("t3.e4.ready", 16'(ld_ready), 16'd0);
        alu_valid = 1'b0;
        tick();   // pop 5; full at the edge so load 7 not yet taken
        check_wr("t3.e5", 1'b1, 3'd5, 8'h11);
        check_eq("t3.e5.count", 16'(lq_count), 16'd1);
        check_eq("t3.e5.ready", 16'(ld_ready), 16'd1);
        tick();   // pop 6, push 7 together
        check_wr("t3.e6", 1'b1, 3'd6, 8'h22);
        check_eq("t3.e6.count", 16'(lq_count), 16'd1);
        ld_valid = 1'b0;
        tick();
        check_wr("t3.e7", 1'b1, 3'd7, 8'h33);
        check_eq("t3.e7.count", 16'(lq_count), 16'd0);
        tick();
        check_wr("t3.e8", 1'b0, 3'd0, 8'h00);

        // 4. scoreboard set/clear, set wins on collision
        issue_valid = 1'b1; issue_rd = 3'd2;
        tick();
        check_eq("sb.set", 16'(pending), 16'h04);
        alu_valid = 1'b1; alu_rd = 3'd2; alu_data = 8'h77;
        tick();
        check_eq("sb.collide", 16'(pending), 16'h04);
        check_wr("sb.w1", 1'b1, 3'd2, 8'h77);
        issue_valid = 1'b0; alu_data = 8'h88;
        tick();
        check_eq("sb.clear", 16'(pending), 16'h00);
        check_wr("sb.w2", 1'b1, 3'd2, 8'h88);
        alu_valid = 1'b0;

        // Load latency and commit clearing pending from the load path
        issue_valid = 1'b1; issue_rd = 3'd5;
        tick();
        check_eq("ldl.pend", 16'(pending), 16'h20);
        issue_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 3'd5; ld_data = 8'h9C;
        tick();
        ld_valid = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
        check_wr("ldl.e1", 1'b1, 3'd5, 8'h9C);
        check_eq("ldl.e1.count", 16'(lq_count), 16'd0);
        check_eq("ldl.e1.pend", 16'(pending), 16'h00);
        tick();
        check_wr("ldl.e2", 1'b0, 3'd0, 8'h00);
`else
        check_wr("ldl.e1", 1'b0, 3'd0, 8'h00);
        check_eq("ldl.e1.count", 16'(lq_count), 16'd1);
        tick();
        check_wr("ldl.e2", 1'b1, 3'd5, 8'h9C);
        check_eq("ldl.e2.count", 16'(lq_count), 16'd0);
`endif
        check_eq("ldl.pend.clr", 16'(pending), 16'h00);

        // 5. load to r0, with an issue to r0 alongside
        ld_valid = 1'b1; ld_rd = 3'd0; ld_data = 8'hFF;
        issue_valid = 1'b1; issue_rd = 3'd0;
        tick();
        ld_valid = 1'b0; issue_valid = 1'b0;
        check_wr("r0.e1", 1'b0, 3'd0, 8'h00);
`ifdef WB_LOAD_BYPASS_EN
        check_eq("r0.e1.count", 16'(lq_count), 16'd0);
`else
        check_eq("r0.e1.count", 16'(lq_count), 16'd1);
`endif
        check_eq("r0.e1.pend", 16'(pending), 16'h00);
        tick();
        check_wr("r0.e2", 1'b0, 3'd0, 8'h00);
        check_eq("r0.e2.count", 16'(lq_count), 16'd0);
        check_eq("r0.e2.pend", 16'(pending), 16'h00);

        // 6. reset with a full queue and a pending bit
        alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 8'h01;
        ld_valid = 1'b1; ld_rd = 3'd3; ld_data = 8'hAA;
        issue_valid = 1'b1; issue_rd = 3'd6;
        tick();
        issue_valid = 1'b0; ld_rd = 3'd4; ld_data = 8'hBB;
        tick();
        check_eq("rst2.pre.count", 16'(lq_count), 16'd2);
        check_eq("rst2.pre.pend", 16'(pending), 16'h40);
        alu_valid = 1'b0; ld_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst2.count", 16'(lq_count), 16'd0);
        check_eq("rst2.pend", 16'(pending), 16'h00);
        check_eq("rst2.ready", 16'(ld_ready), 16'd1);
        check_wr("rst2.e0", 1'b0, 3'd0, 8'h00);
        tick();
        check_wr("rst2.e1", 1'b0, 3'd0, 8'h00);
        tick();
        check_wr("rst2.e2", 1'b0, 3'd0, 8'h00);
        check_eq("rst2.e2.count", 16'(lq_count), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
